// File: rtl/fsm_mult_param.sv
// Sequential multiplier: one shift-add step per cycle, Booth radix-2 for signed
// operands, plain shift-add for unsigned. IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE.
module fsm_mult_param #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     result_q, result_d;
  logic [PW-1:0]     pp;
  logic [WIDTH-1:0]  mplr_q, mplr_d;
  logic              prev_q, prev_d;
  logic              smode_q, smode_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Multiplicand is pre-extended to 2*WIDTH and shifted left each step, so the
  // modulo-2^PW sum of partial products is the exact product in both modes.
  always_comb begin
    pp = '0;
    if (smode_q) begin
      unique case ({mplr_q[0], prev_q})
        2'b01:   pp = mcand_q;
        2'b10:   pp = -mcand_q;
        default: pp = '0;
      endcase
    end else if (mplr_q[0]) begin
      pp = mcand_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    prev_d   = prev_q;
    smode_d  = smode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          acc_d   = '0;
          cnt_d   = '0;
          mplr_d  = b;
          prev_d  = 1'b0;
          smode_d = signed_mode;
          mcand_d = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        end
      end
      RUN: begin
        acc_d   = acc_q + pp;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        prev_d  = mplr_q[0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = acc_q + pp;
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      prev_q   <= 1'b0;
      smode_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      prev_q   <= prev_d;
      smode_q  <= smode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fsm_mult_param.sv
// Bench for fsm_mult_param at WIDTH=4 and WIDTH=8 against a timing/arithmetic
// model: accept starts only when idle, busy for WIDTH+1 cycles, done on the last.
module tb_fsm_mult_param;

  logic        clk = 1'b0;
  logic        rst, start, smode;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  res4;
  logic [15:0] res8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsm_mult_param #(.WIDTH(4)) u_dut4 (
    .clock(clk), .reset(rst), .start(start), .signed_mode(smode),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .result(res4)
  );

  fsm_mult_param #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset(rst), .start(start), .signed_mode(smode),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint prod(longint av, longint bv, bit s, int w);
    longint ea, eb, m;
    ea = av;
    eb = bv;
    if (s && av[w-1]) ea = av - (longint'(1) << w);
    if (s && bv[w-1]) eb = bv - (longint'(1) << w);
    m = (longint'(1) << (2 * w)) - 1;
    return (ea * eb) & m;
  endfunction

  // Model: per design, cycles of busy remaining, pending product, visible result.
  int     m_left[2];
  longint m_prod[2];
  longint m_res[2];
  bit     m_done[2];
  int     m_w[2] = '{4, 8};

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_prod[i] = 0; m_res[i] = 0; m_done[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      longint av, bv;
      av = (i == 0) ? longint'(a4) : longint'(a8);
      bv = (i == 0) ? longint'(b4) : longint'(b8);
      if (rst) begin
        m_left[i] = 0;
        m_res[i]  = 0;
      end else if (m_left[i] == 0) begin
        if (start) begin
          m_left[i] = m_w[i] + 1;
          m_prod[i] = prod(av, bv, smode, m_w[i]);
        end
      end else begin
        m_left[i]--;
      end
      m_done[i] = (m_left[i] == 1);
      if (m_left[i] == 1) m_res[i] = m_prod[i];
    end
  end

  always @(negedge clk) begin
    chk("busy4", busy4, m_left[0] != 0);
    chk("done4", done4, m_done[0]);
    chk("result4", res4, m_res[0]);
    chk("busy8", busy8, m_left[1] != 0);
    chk("done8", done8, m_done[1]);
    chk("result8", res8, m_res[1]);
  end

  // Caller sits at a negedge; start is driven immediately so it can land on the
  // first edge after reset release or right after the previous DONE.
  task automatic run_op4(input bit s, input logic [3:0] av, input logic [3:0] bv,
                         input bit lit, input logic [7:0] exp_res);
    int k;
    smode = s; a4 = av; b4 = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); smode = 1'($urandom);
    k = 1;
    while (!done4 && k < 12) begin
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom);
      k++;
    end
    chk("latency4", k, 5);
    if (lit) begin
      chk("lit_result4", res4, exp_res);
      chk("model_pin4", m_res[0], exp_res);
    end
    @(negedge clk);
  endtask

  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp_res);
    int k;
    repeat (12) @(negedge clk);
    smode = 1'b1; a8 = av; b8 = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    k = 1;
    while (!done8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency8", k, 9);
    chk("lit_result8", res8, exp_res);
    chk("model_pin8", m_res[1], exp_res);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; smode = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy4", busy4, 1'b0);
    chk("reset_result4", res4, 8'h00);
    rst = 1'b0;

    run_op4(1'b1, 4'd4, 4'd3, 1'b1, 8'h0C);
    run_op4(1'b1, 4'h8, 4'h8, 1'b1, 8'h40);
    run_op4(1'b1, 4'h8, 4'h7, 1'b1, 8'hC8);
    run_op4(1'b0, 4'hF, 4'hF, 1'b1, 8'hE1);
    run_op4(1'b1, 4'hF, 4'hF, 1'b1, 8'h01);

    // Start held high with operands changing every cycle.
    smode = 1'b1; a4 = 4'd4; b4 = 4'd3; start = 1'b1;
    dcount = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (done4) dcount++;
      a4 = 4'($urandom); b4 = 4'($urandom); smode = 1'($urandom);
    end
    chk("held_start_dones", dcount, 3);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset sampled at edge 3 of a run.
    smode = 1'b0; a4 = 4'd9; b4 = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy4, 1'b0);
    chk("abort_done", done4, 1'b0);
    chk("abort_result", res4, 8'h00);
    run_op4(1'b1, 4'd5, 4'hD, 1'b1, 8'hF1);

    // Reset and start together.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy4, 1'b0);
    repeat (12) @(negedge clk);

    run_op8(8'h80, 8'h7F, 16'hC080);
    run_op8(8'hFF, 8'hFF, 16'h0001);

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run_op4(1'(s), 4'(x), 4'(y), 1'b0, 8'h00);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      smode = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
